snake_engine: RTL
=================

# snake_engine

Game-state stage directly upstream of the VGA controller in the snake design. Owns the 15x15 board of 2-bit cells (00 world, 01 food, 10 snake), advances the snake once per game tick from button directions, detects collisions, grows on food and re-places food. Serves a registered read port addressed by the VGA controller's 1-based `XLocation`/`YLocation`, returning the cell code the controller colours.

## Interface
- `TICK_DIV`, 12_500_000: clk cycles per game tick (4 Hz at 50 MHz); benches use 64.
- `MAX_LEN`, 32: snake body capacity in segments (circular buffer depth).
- `INIT_LEN`, 3: snake length after reset/restart, at most `MAX_LEN`.

- `clk` in 1: system clock, same clk that feeds the VGA controller.
- `reset` in 1: asynchronous, active-high reset.
- `dir_in` in 2: requested direction: 00 up, 01 right, 10 down, 11 left.
- `dir_valid` in 1: one-cycle strobe qualifying `dir_in`.
- `start` in 1: restart strobe, honoured only in DEAD.
- `x_loc` in 4: read column, 1..15 valid.
- `y_loc` in 4: read row, 1..15 valid.
- `data_out` out 2: cell code at (`x_loc`,`y_loc`), registered.
- `score` out 8: foods eaten, saturates at 255.
- `game_over` out 1: high while in DEAD.
- `busy` out 1: high in CLEAR, INIT, and all move states.

## Operation
- Storage: 225x2 board array, address (y-1)*15+(x-1). Body FIFO of `MAX_LEN` 8-bit (x,y) entries with head and tail pointers. Length counter. 8-bit LFSR x^8+x^6+x^5+x^4+1, seed 8'hA5, stepping every cycle.
- States: CLEAR → INIT → RUN → MOVE → CHECK → UPDATE → (FOOD) → RUN. Collision goes to DEAD.
- CLEAR: writes 00 to addresses 0..224, one per cycle (225 cycles).
- INIT:
  - Writes `INIT_LEN` segments on row 8, head at (8,8) and tail toward smaller x.
  - Writes food at (12,8).
  - Sets direction to right.
  - Goes to RUN.
- Direction: a `dir_valid` strobe latches `dir_in` into the pending direction, except when it reverses the current direction; reversals are dropped. The pending direction becomes the current direction at MOVE. The last strobe before MOVE wins.
- Tick counter: free-running 0..`TICK_DIV`-1 outside CLEAR and INIT. Wrap sets `tick_pend`, which holds one pending tick. RUN goes to MOVE when `tick_pend` is set and clears it.
- MOVE: computes the next head as current head ±1 on x or y, then issues an internal board read at that cell.
- CHECK, using the read result:
  - Dead if the next head is outside 1..15.
  - Dead if the cell is 10 and either (next ≠ tail) or grow.
  - grow = (cell == 01).
- UPDATE:
  - If not grow, or length == `MAX_LEN`: write 00 at the tail and pop the tail.
  - Write 10 at the next head and push it.
  - Length +1 if grow and below `MAX_LEN`.
  - Score +1 if grow, saturating.
  - Goes to FOOD if grow, else RUN.
- FOOD:
  - Candidate cell is x = lfsr[3:0], y = lfsr[7:4].
  - Reject the candidate if either coordinate is 0 or the board cell ≠ 00; retry on the next LFSR value.
  - On accept, write 01 and go to RUN.
- DEAD: board frozen, `game_over`=1. A `start` strobe goes to CLEAR and zeroes score.
- Read port: `data_out` ← board[addr] on each clk. It returns 00 when either coordinate is 0 or above 15, and throughout CLEAR/INIT.

## Timing
- Reset values:
  - state CLEAR, `data_out` 00, `score` 0, `game_over` 0, `busy` 1.
  - LFSR A5, tick counter 0, `tick_pend` 0, direction right.
- Read latency is 1 clk from `x_loc`/`y_loc` to `data_out`. This suits the VGA pixel clock of clk/2.
- A write and a read to the same cell in one cycle returns the old value.
- Tick to board updated:
  - MOVE+CHECK+UPDATE = 3 cycles.
  - FOOD adds ≥1 cycle per attempt.
- A tick arriving while busy in a move is held in `tick_pend`. A second tick in the same window is lost.
- `start` outside DEAD is ignored.
- `reset` mid-move aborts the move immediately; the engine restarts CLEAR on deassert.
- `busy` falls in the cycle RUN is entered after INIT.

## Configuration
- `SNAKE_WRAP_EN`:
  - Defined: walls wrap. x/y below 1 becomes 15 and x/y above 15 becomes 1; only body collisions kill.
  - Undefined: leaving 1..15 goes to DEAD.

## Test plan
- Reset, wait 230 cycles → `data_out`=10 at (6..8,8), 01 at (12,8), 00 elsewhere; `busy`=0; `score`=0.
- 4 ticks with no input → head at (12,8), food eaten, `score`=1, length 4, tail still at (9,8), exactly one new 01 on a previously 00 cell.
- `dir_valid` with `dir_in`=11 while moving right → ignored, head moves to (9,8). Then `dir_in`=00 → next head (9,7).
- Run right to x=15, then one more tick → `game_over`=1, board unchanged. `start` → CLEAR then INIT layout again. With `SNAKE_WRAP_EN` defined, the same tick puts the head at (1,8) instead.
- Reads at (0,5), (5,0), (15,15) after reset → 00, 00, 00. Each read value appears exactly 1 clk after its address.
- Assert `reset` in the UPDATE cycle → `data_out`=00, `score`=0 at once; after deassert, full CLEAR+INIT reproduces the reset board.

Source files
------------

// File: rtl/snake_engine.sv
// snake_engine: 15x15 snake game-state engine feeding the VGA controller.
// Owns the board, steps the snake once per tick, handles food and collisions,
// and serves a 1-cycle registered read port addressed by 1-based (x_loc, y_loc).
// Optional feature: define SNAKE_WRAP_EN to make the walls wrap instead of kill.
module snake_engine #(
  parameter int unsigned TICK_DIV = 12_500_000,
  parameter int unsigned MAX_LEN  = 32,
  parameter int unsigned INIT_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] dir_in,
  input  logic       dir_valid,
  input  logic       start,
  input  logic [3:0] x_loc,
  input  logic [3:0] y_loc,
  output logic [1:0] data_out,
  output logic [7:0] score,
  output logic       game_over,
  output logic       busy
);
  localparam int unsigned CELLS = 225;
  localparam int unsigned AW    = 8;
  localparam int unsigned PW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned LW    = $clog2(MAX_LEN + 1);
  localparam int unsigned TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] CELL_WORLD = 2'b00;
  localparam logic [1:0] CELL_FOOD  = 2'b01;
  localparam logic [1:0] CELL_SNAKE = 2'b10;
  localparam logic [1:0] DIR_UP     = 2'b00;
  localparam logic [1:0] DIR_RIGHT  = 2'b01;
  localparam logic [1:0] DIR_DOWN   = 2'b10;

  typedef enum logic [2:0] {
    S_CLEAR, S_INIT, S_RUN, S_MOVE, S_CHECK, S_UPDATE, S_FOOD, S_DEAD
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      board_q [CELLS];
  logic [7:0]      body_q  [MAX_LEN];   // {x, y} per segment
  logic [PW-1:0]   head_ptr_q, tail_ptr_q;
  logic [LW-1:0]   len_q;
  logic [AW-1:0]   clr_cnt_q;
  logic [TW-1:0]   tick_cnt_q;
  logic            tick_pend_q;
  logic [1:0]      cur_dir_q, pend_dir_q;
  logic [7:0]      lfsr_q, score_q;
  logic [3:0]      nx_q, ny_q;
  logic [1:0]      cell_q, data_out_q;
  logic            busy_q, game_over_q, busy_d, game_over_d;

  logic [3:0]      head_x_c, head_y_c, step_x_c, step_y_c, food_x_c, food_y_c;
  logic [7:0]      tail_c;
  logic            grow_c, hit_c, food_ok_c, tick_wrap_c;

  function automatic logic [AW-1:0] cell_addr(input logic [3:0] x, input logic [3:0] y);
    return AW'({4'd0, y} - 8'd1) * AW'(15) + AW'({4'd0, x} - 8'd1);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_LEN - 1)) ? '0 : p + PW'(1);
  endfunction

  assign data_out  = data_out_q;
  assign score     = score_q;
  assign game_over = game_over_q;
  assign busy      = busy_q;

  // Next head, collision, growth and food-candidate decode
  always_comb begin
    head_x_c  = body_q[head_ptr_q][7:4];
    head_y_c  = body_q[head_ptr_q][3:0];
    tail_c    = body_q[tail_ptr_q];
    step_x_c  = head_x_c;
    step_y_c  = head_y_c;
    case (pend_dir_q)
      DIR_UP:    step_y_c = head_y_c - 4'd1;
      DIR_RIGHT: step_x_c = head_x_c + 4'd1;
      DIR_DOWN:  step_y_c = head_y_c + 4'd1;
      default:   step_x_c = head_x_c - 4'd1;
    endcase
`ifdef SNAKE_WRAP_EN
    // 4-bit stepping turns both 0 and 16 into 0; the old head tells which wall
    if (step_x_c == 4'd0) step_x_c = (head_x_c == 4'd15) ? 4'd1 : 4'd15;
    if (step_y_c == 4'd0) step_y_c = (head_y_c == 4'd15) ? 4'd1 : 4'd15;
`endif
    grow_c = (cell_q == CELL_FOOD);
    hit_c  = (nx_q == 4'd0) || (ny_q == 4'd0) ||
             ((cell_q == CELL_SNAKE) && (({nx_q, ny_q} != tail_c) || grow_c));
    food_x_c  = lfsr_q[3:0];
    food_y_c  = lfsr_q[7:4];
    food_ok_c = 1'b0;
    if ((food_x_c != 4'd0) && (food_y_c != 4'd0))
      food_ok_c = (board_q[cell_addr(food_x_c, food_y_c)] == CELL_WORLD);
    tick_wrap_c = (tick_cnt_q == TW'(TICK_DIV - 1));
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_CLEAR;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR:  if (clr_cnt_q == AW'(CELLS - 1)) state_d = S_INIT;
      S_INIT:   state_d = S_RUN;
      S_RUN:    if (tick_pend_q) state_d = S_MOVE;
      S_MOVE:   state_d = S_CHECK;
      S_CHECK:  state_d = hit_c ? S_DEAD : S_UPDATE;
      S_UPDATE: state_d = grow_c ? S_FOOD : S_RUN;
      S_FOOD:   if (food_ok_c) state_d = S_RUN;
      S_DEAD:   if (start) state_d = S_CLEAR;
      default:  state_d = S_CLEAR;
    endcase
  end

  // Output decode from the upcoming state so the registered flags track state_q
  always_comb begin
    busy_d      = 1'b1;
    game_over_d = 1'b0;
    case (state_d)
      S_RUN:   busy_d = 1'b0;
      S_DEAD:  begin busy_d = 1'b0; game_over_d = 1'b1; end
      default: ;
    endcase
  end

  // Control datapath: counters, direction, pointers, score, LFSR, read port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_cnt_q   <= '0;
      tick_cnt_q  <= '0;
      tick_pend_q <= 1'b0;
      cur_dir_q   <= DIR_RIGHT;
      pend_dir_q  <= DIR_RIGHT;
      head_ptr_q  <= '0;
      tail_ptr_q  <= '0;
      len_q       <= '0;
      score_q     <= '0;
      lfsr_q      <= 8'hA5;
      nx_q        <= '0;
      ny_q        <= '0;
      cell_q      <= CELL_WORLD;
      data_out_q  <= CELL_WORLD;
      busy_q      <= 1'b1;
      game_over_q <= 1'b0;
    end else begin
      lfsr_q      <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      busy_q      <= busy_d;
      game_over_q <= game_over_d;
      clr_cnt_q   <= (state_q == S_CLEAR) ? clr_cnt_q + AW'(1) : '0;

      if (state_q == S_CLEAR || state_q == S_INIT) begin
        tick_cnt_q  <= '0;
        tick_pend_q <= 1'b0;
      end else begin
        tick_cnt_q <= tick_wrap_c ? '0 : tick_cnt_q + TW'(1);
        if (tick_wrap_c)                          tick_pend_q <= 1'b1;
        else if (state_q == S_RUN && tick_pend_q) tick_pend_q <= 1'b0;
      end

      // Reversal test uses the direction about to be current during MOVE
      if (state_q == S_INIT) begin
        cur_dir_q  <= DIR_RIGHT;
        pend_dir_q <= DIR_RIGHT;
      end else begin
        if (dir_valid &&
            dir_in != (((state_q == S_MOVE) ? pend_dir_q : cur_dir_q) ^ 2'b10))
          pend_dir_q <= dir_in;
        if (state_q == S_MOVE) cur_dir_q <= pend_dir_q;
      end

      if (state_q == S_INIT) begin
        head_ptr_q <= PW'(INIT_LEN - 1);
        tail_ptr_q <= '0;
        len_q      <= LW'(INIT_LEN);
      end

      if (state_q == S_MOVE) begin
        nx_q   <= step_x_c;
        ny_q   <= step_y_c;
        cell_q <= ((step_x_c != 4'd0) && (step_y_c != 4'd0)) ?
                  board_q[cell_addr(step_x_c, step_y_c)] : CELL_WORLD;
      end

      if (state_q == S_UPDATE) begin
        if (!grow_c || len_q == LW'(MAX_LEN)) tail_ptr_q <= ptr_inc(tail_ptr_q);
        head_ptr_q <= ptr_inc(head_ptr_q);
        if (grow_c && len_q != LW'(MAX_LEN)) len_q <= len_q + LW'(1);
        if (grow_c && score_q != 8'hFF)     score_q <= score_q + 8'd1;
      end

      if (state_q == S_DEAD && start) score_q <= '0;

      if (state_q == S_CLEAR || state_q == S_INIT || x_loc == 4'd0 || y_loc == 4'd0)
        data_out_q <= CELL_WORLD;
      else
        data_out_q <= board_q[cell_addr(x_loc, y_loc)];
    end
  end

  // Board and body storage; CLEAR/INIT rebuild them so no reset is needed
  always_ff @(posedge clk) begin
    case (state_q)
      S_CLEAR: board_q[clr_cnt_q] <= CELL_WORLD;
      S_INIT: begin
        for (int i = 0; i < int'(INIT_LEN); i++) begin
          board_q[cell_addr(4'(9 - int'(INIT_LEN) + i), 4'd8)] <= CELL_SNAKE;
          body_q[PW'(i)] <= {4'(9 - int'(INIT_LEN) + i), 4'd8};
        end
        board_q[cell_addr(4'd12, 4'd8)] <= CELL_FOOD;
      end
      S_UPDATE: begin
        // Tail clear first so a head moving into the vacated tail cell wins
        if (!grow_c || len_q == LW'(MAX_LEN))
          board_q[cell_addr(tail_c[7:4], tail_c[3:0])] <= CELL_WORLD;
        board_q[cell_addr(nx_q, ny_q)] <= CELL_SNAKE;
        body_q[ptr_inc(head_ptr_q)]    <= {nx_q, ny_q};
      end
      S_FOOD: if (food_ok_c) board_q[cell_addr(food_x_c, food_y_c)] <= CELL_FOOD;
      default: ;
    endcase
  end

endmodule
